// File: rtl/dawn_pkg.sv
// rtl/dawn_pkg.sv - shared status codes, register sentinel and scheduler state encoding
package dawn_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR_M   = 2'd1,
    S_HALTED = 2'd2
  } sched_state_t;

  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// rtl/regfile_wr_sched_if.sv - writeback-stage to write-scheduler handshake bundle
interface regfile_wr_sched_if;

  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [3:0]  icode_i;
  logic [3:0]  dstE_i;
  logic [3:0]  dstM_i;
  logic [63:0] valE_i;
  logic [63:0] valM_i;
  logic        instr_valid_i;
  logic        hlt_i;
  logic        instr_error_i;
  logic        imem_error_i;

  modport master (
    output wb_valid_i, icode_i, dstE_i, dstM_i, valE_i, valM_i,
    output instr_valid_i, hlt_i, instr_error_i, imem_error_i,
    input  wb_ready_o
  );

  modport slave (
    input  wb_valid_i, icode_i, dstE_i, dstM_i, valE_i, valM_i,
    input  instr_valid_i, hlt_i, instr_error_i, imem_error_i,
    output wb_ready_o
  );

endinterface

// File: rtl/stat_encode.sv
// rtl/stat_encode.sv - combinational status classification of a writeback instruction
module stat_encode
  import dawn_pkg::*;
(
  input  logic  imem_error,
  input  logic  instr_error,
  input  logic  instr_valid,
  input  logic  hlt,
  output stat_t stat
);

  // Fetch-side address faults outrank decode faults, which outrank halt.
  always_comb begin
    stat = STAT_AOK;
    if (imem_error)
      stat = STAT_ADR;
    else if (instr_error || !instr_valid)
      stat = STAT_INS;
    else if (hlt)
      stat = STAT_HLT;
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - serialises Y86-64 dual writebacks onto one register-file write port
module regfile_wr_sched
  import dawn_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  regfile_wr_sched_if.slave    wb,
  output logic                 rf_we_o,
  output logic [3:0]           rf_dst_o,
  output logic [63:0]          rf_data_o,
  output logic [2:0]           stat_o,
  output logic                 halted_o,
  output logic [CNT_W-1:0]     retired_o
);

  sched_state_t     state;
  stat_t            stat_q;
  stat_t            xfer_stat;
  logic [3:0]       pend_dst;
  logic [63:0]      pend_data;
  logic             e_used;
  logic             m_used;
  logic             xfer;

  stat_encode u_stat_encode (
    .imem_error  (wb.imem_error_i),
    .instr_error (wb.instr_error_i),
    .instr_valid (wb.instr_valid_i),
    .hlt         (wb.hlt_i),
    .stat        (xfer_stat)
  );

  assign wb.wb_ready_o = (state == S_IDLE);
  assign xfer          = wb.wb_valid_i && wb.wb_ready_o;
  assign e_used        = (wb.dstE_i != RNONE);
  assign m_used        = (wb.dstM_i != RNONE);
  assign stat_o        = stat_q;
  assign halted_o      = (stat_q != STAT_AOK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      rf_we_o   <= 1'b0;
      rf_dst_o  <= RNONE;
      rf_data_o <= 64'd0;
      stat_q    <= STAT_AOK;
      retired_o <= '0;
      pend_dst  <= RNONE;
      pend_data <= 64'd0;
    end else begin
      rf_we_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if (xfer_stat != STAT_AOK) begin
              stat_q <= xfer_stat;
              state  <= S_HALTED;
            end else begin
              retired_o <= retired_o + CNT_W'(1);
              // Same destination on both ports: the memory value is architecturally last.
              if (m_used && (!e_used || wb.dstE_i == wb.dstM_i)) begin
                rf_we_o   <= 1'b1;
                rf_dst_o  <= wb.dstM_i;
                rf_data_o <= wb.valM_i;
              end else if (e_used) begin
                rf_we_o   <= 1'b1;
                rf_dst_o  <= wb.dstE_i;
                rf_data_o <= wb.valE_i;
                if (m_used) begin
                  pend_dst  <= wb.dstM_i;
                  pend_data <= wb.valM_i;
                  state     <= S_WR_M;
                end
              end
            end
          end
        end
        S_WR_M: begin
          rf_we_o   <= 1'b1;
          rf_dst_o  <= pend_dst;
          rf_data_o <= pend_data;
          state     <= S_IDLE;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb/tb_regfile_wr_sched.sv - directed self-checking bench for regfile_wr_sched
module tb_regfile_wr_sched;

  logic        clk_i;
  logic        rst_n_i;
  logic        rf_we_o;
  logic [3:0]  rf_dst_o;
  logic [63:0] rf_data_o;
  logic [2:0]  stat_o;
  logic        halted_o;
  logic [3:0]  retired_o;

  int checks;
  int failures;

  regfile_wr_sched_if wb_if ();

  regfile_wr_sched #(.CNT_W(4)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wb        (wb_if.slave),
    .rf_we_o   (rf_we_o),
    .rf_dst_o  (rf_dst_o),
    .rf_data_o (rf_data_o),
    .stat_o    (stat_o),
    .halted_o  (halted_o),
    .retired_o (retired_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_if.wb_valid_i    = 1'b0;
    wb_if.icode_i       = 4'h0;
    wb_if.dstE_i        = 4'hF;
    wb_if.dstM_i        = 4'hF;
    wb_if.valE_i        = 64'd0;
    wb_if.valM_i        = 64'd0;
    wb_if.instr_valid_i = 1'b1;
    wb_if.hlt_i         = 1'b0;
    wb_if.instr_error_i = 1'b0;
    wb_if.imem_error_i  = 1'b0;
  endtask

  // Present one instruction for exactly one rising edge, then withdraw it.
  task automatic xfer(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm,
                      input logic iv, input logic h, input logic ie, input logic ime);
    wb_if.wb_valid_i    = 1'b1;
    wb_if.icode_i       = 4'hB;
    wb_if.dstE_i        = de;
    wb_if.valE_i        = ve;
    wb_if.dstM_i        = dm;
    wb_if.valM_i        = vm;
    wb_if.instr_valid_i = iv;
    wb_if.hlt_i         = h;
    wb_if.instr_error_i = ie;
    wb_if.imem_error_i  = ime;
    @(posedge clk_i);
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    idle_inputs();
    step();
    rst_n_i = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("rst_we",      rf_we_o,   1'b0);
    chk("rst_dst",     rf_dst_o,  4'hF);
    chk("rst_data",    rf_data_o, 64'd0);
    chk("rst_stat",    stat_o,    3'd1);
    chk("rst_halted",  halted_o,  1'b0);
    chk("rst_retired", retired_o, 4'd0);
    rst_n_i = 1'b1;
    chk("rel_ready", wb_if.wb_ready_o, 1'b1);

    // irmovq: single E write
    xfer(4'h2, 64'h55, 4'hF, 64'h0, 1, 0, 0, 0);
    chk("irm_we",      rf_we_o,   1'b1);
    chk("irm_dst",     rf_dst_o,  4'h2);
    chk("irm_data",    rf_data_o, 64'h55);
    chk("irm_retired", retired_o, 4'd1);
    chk("irm_ready",   wb_if.wb_ready_o, 1'b1);
    step();
    chk("idle_we",   rf_we_o,   1'b0);
    chk("idle_hold", rf_dst_o,  4'h2);

    // popq: E then M over two cycles with stall
    xfer(4'h4, 64'h108, 4'h3, 64'hAA, 1, 0, 0, 0);
    chk("pop_e_we",    rf_we_o,   1'b1);
    chk("pop_e_dst",   rf_dst_o,  4'h4);
    chk("pop_e_data",  rf_data_o, 64'h108);
    chk("pop_e_ready", wb_if.wb_ready_o, 1'b0);
    chk("pop_retired", retired_o, 4'd2);
    step();
    chk("pop_m_we",    rf_we_o,   1'b1);
    chk("pop_m_dst",   rf_dst_o,  4'h3);
    chk("pop_m_data",  rf_data_o, 64'hAA);
    chk("pop_m_ready", wb_if.wb_ready_o, 1'b1);
    step();
    chk("pop_after_we", rf_we_o, 1'b0);

    // popq %rsp: M wins, single cycle
    xfer(4'h4, 64'h108, 4'h4, 64'h77, 1, 0, 0, 0);
    chk("rsp_we",    rf_we_o,   1'b1);
    chk("rsp_dst",   rf_dst_o,  4'h4);
    chk("rsp_data",  rf_data_o, 64'h77);
    chk("rsp_ready", wb_if.wb_ready_o, 1'b1);
    step();
    chk("rsp_no_second", rf_we_o, 1'b0);

    // nop: nothing written, still retired
    xfer(4'hF, 64'h1, 4'hF, 64'h2, 1, 0, 0, 0);
    chk("nop_we",      rf_we_o,   1'b0);
    chk("nop_retired", retired_o, 4'd4);

    // back-to-back single writes
    wb_if.wb_valid_i = 1'b1;
    wb_if.dstE_i = 4'h5; wb_if.valE_i = 64'h1;
    step();
    chk("b2b0_dst",  rf_dst_o,  4'h5);
    chk("b2b0_data", rf_data_o, 64'h1);
    chk("b2b0_rdy",  wb_if.wb_ready_o, 1'b1);
    wb_if.dstE_i = 4'hF; wb_if.dstM_i = 4'h6; wb_if.valM_i = 64'h2;
    step();
    idle_inputs();
    chk("b2b1_we",   rf_we_o,   1'b1);
    chk("b2b1_dst",  rf_dst_o,  4'h6);
    chk("b2b1_data", rf_data_o, 64'h2);
    chk("b2b1_ret",  retired_o, 4'd6);

    // reset while M write pending
    xfer(4'h1, 64'h10, 4'h7, 64'h20, 1, 0, 0, 0);
    chk("wrm_e_dst", rf_dst_o, 4'h1);
    chk("wrm_ready", wb_if.wb_ready_o, 1'b0);
    rst_n_i = 1'b0;
    #1;
    chk("wrm_rst_we",   rf_we_o,   1'b0);
    chk("wrm_rst_dst",  rf_dst_o,  4'hF);
    chk("wrm_rst_data", rf_data_o, 64'd0);
    chk("wrm_rst_stat", stat_o,    3'd1);
    chk("wrm_rst_ret",  retired_o, 4'd0);
    step();
    rst_n_i = 1'b1;
    chk("wrm_rel_ready", wb_if.wb_ready_o, 1'b1);
    step();
    chk("wrm_no_m_we",  rf_we_o,  1'b0);
    chk("wrm_no_m_dst", rf_dst_o, 4'hF);

    // counter wrap: 17 AOK transfers on a 4-bit counter
    wb_if.wb_valid_i = 1'b1;
    wb_if.dstE_i = 4'h8;
    for (int i = 0; i < 17; i++) begin
      wb_if.valE_i = 64'(i);
      step();
    end
    idle_inputs();
    chk("wrap_retired", retired_o, 4'd1);
    chk("wrap_last",    rf_data_o, 64'd16);

    // hlt and imem_error together -> ADR
    xfer(4'h2, 64'h99, 4'hF, 64'h0, 1, 1, 0, 1);
    chk("adr_stat",    stat_o,    3'd3);
    chk("adr_halted",  halted_o,  1'b1);
    chk("adr_we",      rf_we_o,   1'b0);
    chk("adr_ready",   wb_if.wb_ready_o, 1'b0);
    chk("adr_retired", retired_o, 4'd1);
    xfer(4'h2, 64'h99, 4'hF, 64'h0, 1, 0, 0, 0);
    chk("hlt_sticky_we",   rf_we_o,   1'b0);
    chk("hlt_sticky_stat", stat_o,    3'd3);
    chk("hlt_sticky_ret",  retired_o, 4'd1);
    chk("hlt_sticky_rdy",  wb_if.wb_ready_o, 1'b0);

    // instr_error outranks hlt -> INS
    do_reset();
    xfer(4'h2, 64'h1, 4'hF, 64'h0, 1, 1, 1, 0);
    chk("ins_err_stat", stat_o,  3'd4);
    chk("ins_err_we",   rf_we_o, 1'b0);

    // invalid instruction -> INS
    do_reset();
    xfer(4'h2, 64'h1, 4'hF, 64'h0, 0, 0, 0, 0);
    chk("ins_inv_stat", stat_o, 3'd4);

    // plain halt -> HLT, no retire
    do_reset();
    xfer(4'h2, 64'h1, 4'hF, 64'h0, 1, 1, 0, 0);
    chk("hlt_stat",    stat_o,    3'd2);
    chk("hlt_halted",  halted_o,  1'b1);
    chk("hlt_retired", retired_o, 4'd0);
    chk("hlt_dst",     rf_dst_o,  4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
